// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with an iterative radix-2 multiply/divide unit and HI/LO registers.
// Single-cycle ops complete one edge after accept; MULT/DIV take WIDTH iterations plus a commit cycle.
module alu_mdu_seq #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       opa_q, opa_d;
    logic                   neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic                   div_q, div_d, dz_q, dz_d, eq_q, eq_d;
    logic                   out_valid_q, out_valid_d, zero_q, zero_d;
    logic [WIDTH-1:0]       result_q, result_d, hi_q, hi_d, lo_q, lo_d;

    logic                   accept, is_mul, is_div, is_sgn, a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag, single_res;
    logic [WIDTH:0]         mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    assign is_mul = (sel == 4'd5) || (sel == 4'd8);
    assign is_div = ENABLE_DIV && ((sel == 4'd9) || (sel == 4'd10));
    assign is_sgn = (sel == 4'd5) || (sel == 4'd9);
    assign a_neg  = is_sgn && dataA[WIDTH-1];
    assign b_neg  = is_sgn && dataB[WIDTH-1];
    assign a_mag  = a_neg ? -dataA : dataA;
    assign b_mag  = b_neg ? -dataB : dataB;

    // Both engines work on magnitudes; signs are reapplied when the result commits.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, mcand_q};
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        single_res = '0;
        case (sel)
            4'd0:    single_res = dataA + dataB;
            4'd1:    single_res = dataA - dataB;
            4'd2:    single_res = dataA & dataB;
            4'd3:    single_res = dataA | dataB;
            4'd4:    single_res = dataA ^ dataB;
            4'd6:    single_res = hi_q;
            4'd7:    single_res = lo_q;
            4'd11:   single_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            4'd12:   single_res = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
            4'd13:   single_res = ~(dataA | dataB);
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        opa_d       = opa_q;
        neg_d       = neg_q;
        neg_rem_d   = neg_rem_q;
        div_d       = div_q;
        dz_d        = dz_q;
        eq_d        = eq_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    eq_d      = (dataA == dataB);
                    opa_d     = dataA;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = (dataB == '0);
                    div_d     = is_div;
                    cnt_d     = '0;
                    if (is_mul) begin
                        state_d = S_MUL;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        mcand_d = a_mag;
                    end else if (is_div) begin
                        state_d = S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        mcand_d = b_mag;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = single_res;
                        zero_d      = (dataA == dataB);
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else if (!rem_diff[WIDTH]) begin
                    acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (!div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                out_valid_d = 1'b1;
                result_d    = lo_d;
                zero_d      = eq_q;
            end
        endcase

        // A kill drops the in-flight op, including a commit that would land on this edge.
        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            result_d    = result_q;
            zero_d      = zero_q;
            hi_d        = hi_q;
            lo_d        = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            opa_q       <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_q       <= 1'b0;
            dz_q        <= 1'b0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            opa_q       <= opa_d;
            neg_q       <= neg_d;
            neg_rem_q   <= neg_rem_d;
            div_q       <= div_d;
            dz_q        <= dz_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = (state_q != S_IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq (WIDTH=32): single-cycle ops, MULT/DIV latency and corner
// cases, output backpressure, flush/reset aborts, and a short seeded stream against a model.
module tb_alu_mdu_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    alu_mdu_seq #(.WIDTH(32), .ENABLE_DIV(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .dataA(dataA), .dataB(dataB), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits (bounded) for in_ready, and returns #1 after the accept edge.
    task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1; sel = s; dataA = a; dataB = b;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("issue_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; sel = 4'd0; dataA = 32'hDEAD_BEEF; dataB = 32'h1234_5678;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
        int n;
        issue(s, a, b);
        wait_valid(n);
        $display("txn %s sel=%0d a=%h b=%h result=%h zero=%0b lat=%0d", tag, s, a, b, result, zero, n);
        chk({tag, "_lat"}, n, 0);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    endtask

    task automatic run_mdu(input string tag, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(s, a, b);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_valid(n);
        $display("txn %s sel=%0d a=%h b=%h hi=%h lo=%h lat=%0d", tag, s, a, b, hi, lo, n);
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_res"}, result, exp_lo);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic [63:0] p;
        logic [3:0]  rs;
        logic        seen;
        logic [3:0]  ops [8];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12, 4'd13};

        rst = 1'b1; in_valid = 1'b0; sel = 4'd0; dataA = '0; dataB = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single-cycle ALU ops
        run_op("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
        run_op("sub_eq",   4'd1, 32'd5, 32'd5, 32'd0, 1'b1);
        run_op("slt",      4'd11, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        run_op("sltu",     4'd12, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_op("nor",      4'd13, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0);
        run_op("xor",      4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
        run_op("sel15",    4'd15, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0);

        // Multiply
        run_mdu("mult",  4'd5, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_mdu("multu", 4'd8, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFA);
        run_op("mfhi", 4'd6, 32'd0, 32'd1, 32'd2, 1'b0);
        run_op("mflo", 4'd7, 32'd0, 32'd1, 32'hFFFF_FFFA, 1'b0);
        run_mdu("mult_sq", 4'd5, 32'd3, 32'd3, 32'd0, 32'd9);
        chk("mult_sq_zero", {31'd0, zero}, 32'd1);

        // Divide
        run_mdu("div_neg",  4'd9,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_mdu("divu_z",   4'd10, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_mdu("div_ovf",  4'd9,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_mdu("divu_100", 4'd10, 32'd100, 32'd7, 32'd2, 32'd14);

        // Backpressure: held result blocks new requests, release accepts on the same edge
        tick();
        out_ready = 1'b0;
        run_op("bp_add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0);
        in_valid = 1'b1; sel = 4'd2; dataA = 32'h0000_00F0; dataB = 32'h0000_003C;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", result, 32'd5);
            tick();
        end
        chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        $display("txn bp_and result=%h out_valid=%0b", result, out_valid);
        chk("bp_and_res", result, 32'h0000_0030);
        chk("bp_and_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // Flush at iteration 10 of a MULT
        issue(4'd5, 32'd5, 32'd6);
        repeat (10) tick();
        flush = 1'b1;
        in_valid = 1'b1; sel = 4'd0; dataA = 32'd1; dataB = 32'd1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        $display("txn flush_mid hi=%h lo=%h seen_valid=%0b", hi, lo, seen);
        chk("flush_no_valid", {31'd0, seen}, 32'd0);
        chk("flush_hi", hi, 32'd2);
        chk("flush_lo", lo, 32'd14);

        // Flush on the commit edge suppresses the HI/LO write
        issue(4'd5, 32'd7, 32'd9);
        repeat (32) tick();
        chk("done_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("txn flush_done hi=%h lo=%h out_valid=%0b", hi, lo, out_valid);
        chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_done_hi", hi, 32'd2);
        chk("flush_done_lo", lo, 32'd14);
        chk("flush_done_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a DIV
        issue(4'd10, 32'd1000, 32'd3);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        $display("txn rst_mid busy=%0b out_valid=%0b hi=%h lo=%h", busy, out_valid, hi, lo);
        chk("rstm_busy", {31'd0, busy}, 32'd0);
        chk("rstm_valid", {31'd0, out_valid}, 32'd0);
        chk("rstm_result", result, 32'd0);
        chk("rstm_zero", {31'd0, zero}, 32'd0);
        chk("rstm_hi", hi, 32'd0);
        chk("rstm_lo", lo, 32'd0);
        rst = 1'b0;
        tick();

        // Seeded mixed stream against a reference model, with occasional output stalls
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 3) begin
                rs = (i % 8 == 3) ? 4'd5 : 4'd8;
                if (rs == 4'd5) p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
                else            p = {32'd0, ra} * {32'd0, rb};
                run_mdu("rnd_mul", rs, ra, rb, p[63:32], p[31:0]);
            end else if (i % 4 == 1 && i > 4) begin
                rb = $urandom_range(1, 1000);
                run_mdu("rnd_divu", 4'd10, ra, rb, ra % rb, ra / rb);
            end else begin
                rs = ops[$urandom_range(0, 7)];
                case (rs)
                    4'd0:    er = ra + rb;
                    4'd1:    er = ra - rb;
                    4'd2:    er = ra & rb;
                    4'd3:    er = ra | rb;
                    4'd4:    er = ra ^ rb;
                    4'd11:   er = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
                    4'd12:   er = (ra < rb) ? 32'd1 : 32'd0;
                    default: er = ~(ra | rb);
                endcase
                run_op("rnd_alu", rs, ra, rb, er, 1'b0);
                if ($urandom_range(0, 1) == 1) begin
                    out_ready = 1'b0;
                    repeat (2) tick();
                    chk("rnd_stall_res", result, er);
                    chk("rnd_stall_valid", {31'd0, out_valid}, 32'd1);
                    out_ready = 1'b1;
                    tick();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
